// File: rtl/dbg_host_ctrl.sv
// Host-side sequencer for the debug register window: decodes host command bytes,
// arbitrates for the data bus, performs one debug-bus access and returns read data.
module dbg_host_ctrl #(
   parameter int              l       = 16,
   parameter logic [l-5:0]    dbgaddr = 12'hFFE
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   output logic         rx_ready,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic         bus_req,
   input  logic         bus_gnt,
   output logic [l-2:0] addr,
   output logic [l-1:0] data,
   output logic         r,
   output logic [1:0]   w,
   input  logic [l-1:0] rdata,
   output logic         busy
);

   // Handshakes: a byte moves on rx when rx_valid&rx_ready at a rising edge, and on
   // tx when tx_valid&tx_ready; tx_data/tx_valid stay fixed while tx_ready is low.
   typedef enum logic [3:0] {
      S_IDLE, S_WHI, S_WLO, S_REQ, S_BUS, S_RDLAT, S_TXHI, S_TXLO, S_ERR
   } state_t;

   state_t       r_state;
   state_t       w_next;
   logic [2:0]   r_idx;
   logic         r_read;
   logic [l-1:0] r_wdata;
   logic [l-1:0] r_rd;
   logic         w_rx_ready;
   logic         w_rx_fire;
   logic         w_cmd_bad;

   assign w_rx_ready = (r_state == S_IDLE) || (r_state == S_WHI) || (r_state == S_WLO);
   assign w_rx_fire  = rx_valid && w_rx_ready;
   assign w_cmd_bad  = (rx_data[6:4] != 3'b000) || rx_data[0];

   assign rx_ready = w_rx_ready;
   assign addr     = {dbgaddr, r_idx};
   assign data     = r_wdata;
   assign busy     = (r_state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      bus_req  = 1'b0;
      r        = 1'b0;
      w        = 2'b00;
      case (r_state)
         S_IDLE: begin
            if (w_rx_fire) begin
               if (w_cmd_bad)       w_next = S_ERR;
               else if (rx_data[7]) w_next = S_REQ;
               else                 w_next = S_WHI;
            end
         end
         S_WHI: if (w_rx_fire) w_next = S_WLO;
         S_WLO: if (w_rx_fire) w_next = S_REQ;
         S_REQ: begin
            bus_req = 1'b1;
            if (bus_gnt) w_next = S_BUS;
         end
         S_BUS: begin
            // Granted access is always completed, even if gnt drops this cycle.
            bus_req = 1'b1;
            r       = r_read;
            w       = r_read ? 2'b00 : 2'b11;
            w_next  = r_read ? S_RDLAT : S_IDLE;
         end
         S_RDLAT: w_next = S_TXHI;
         S_TXHI: begin
            tx_valid = 1'b1;
            tx_data  = r_rd[l-1:l-8];
            if (tx_ready) w_next = S_TXLO;
         end
         S_TXLO: begin
            tx_valid = 1'b1;
            tx_data  = r_rd[7:0];
            if (tx_ready) w_next = S_IDLE;
         end
         S_ERR: begin
            tx_valid = 1'b1;
            tx_data  = 8'hEE;
            if (tx_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx   <= 3'h0;
         r_read  <= 1'b0;
         r_wdata <= '0;
         r_rd    <= '0;
      end else begin
         if ((r_state == S_IDLE) && w_rx_fire && !w_cmd_bad) begin
            r_idx  <= rx_data[3:1];
            r_read <= rx_data[7];
         end
         // Two shifts assemble the write word MSB byte first.
         if (((r_state == S_WHI) || (r_state == S_WLO)) && w_rx_fire)
            r_wdata <= {r_wdata[l-9:0], rx_data};
         if (r_state == S_RDLAT)
            r_rd <= rdata;
      end
   end

endmodule

// File: tb/tb_dbg_host_ctrl.sv
// Directed bench for dbg_host_ctrl: write, read, illegal command, grant stall,
// tx backpressure, mid-command reset and back-to-back writes.
module tb_dbg_host_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        bus_req;
   logic        bus_gnt = 1'b0;
   logic [14:0] addr;
   logic [15:0] data;
   logic        r;
   logic [1:0]  w;
   logic [15:0] rdata = 16'h0000;
   logic        busy;

   logic [15:0] rd_val = 16'h0000;
   int          passed = 0;
   int          total = 0;

   int          w_cnt = 0;
   int          r_cnt = 0;
   int          both_cnt = 0;
   logic [14:0] w_addr = '0;
   logic [15:0] w_data = '0;
   logic [14:0] r_addr = '0;
   logic [7:0]  tx_log[$];

   dbg_host_ctrl dut (
      .clk(clk), .reset(reset),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .bus_req(bus_req), .bus_gnt(bus_gnt),
      .addr(addr), .data(data), .r(r), .w(w), .rdata(rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // Bus slave: read data appears the cycle after the r strobe.
   always @(posedge clk) rdata <= r ? rd_val : 16'h0000;

   always @(negedge clk) begin
      if (w == 2'b11) begin
         w_cnt  = w_cnt + 1;
         w_addr = addr;
         w_data = data;
      end
      if (r) begin
         r_cnt  = r_cnt + 1;
         r_addr = addr;
      end
      if (r && (w != 2'b00)) both_cnt = both_cnt + 1;
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (rx_ready) begin
            ok = 1;
            break;
         end
         tick();
      end
      total++;
      if (!ok) $display("FAIL send_byte timeout: byte %h not accepted, rx_ready=%b required 1", b, rx_ready);
      else passed++;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         if (!busy) begin
            ok = 1;
            break;
         end
         tick();
      end
      total++;
      if (!ok) $display("FAIL %s idle timeout: busy=%b required 0", name, busy);
      else passed++;
   endtask

   task automatic wait_tx(input string name, input int n);
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         if (tx_log.size() >= n) begin
            ok = 1;
            break;
         end
         tick();
      end
      total++;
      if (!ok) $display("FAIL %s tx timeout: got %0d bytes required %0d", name, tx_log.size(), n);
      else passed++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick(); tick();
      total++; if (rx_ready !== 1'b1)         $display("FAIL reset rx_ready: got %b required 1", rx_ready); else passed++;
      total++; if (tx_valid !== 1'b0)         $display("FAIL reset tx_valid: got %b required 0", tx_valid); else passed++;
      total++; if (tx_data !== 8'h00)         $display("FAIL reset tx_data: got %h required 00", tx_data); else passed++;
      total++; if (bus_req !== 1'b0)          $display("FAIL reset bus_req: got %b required 0", bus_req); else passed++;
      total++; if (r !== 1'b0)                $display("FAIL reset r: got %b required 0", r); else passed++;
      total++; if (w !== 2'b00)               $display("FAIL reset w: got %b required 00", w); else passed++;
      total++; if (addr !== {12'hFFE, 3'h0})  $display("FAIL reset addr: got %h required %h", addr, {12'hFFE, 3'h0}); else passed++;
      total++; if (data !== 16'h0000)         $display("FAIL reset data: got %h required 0000", data); else passed++;
      total++; if (busy !== 1'b0)             $display("FAIL reset busy: got %b required 0", busy); else passed++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_write();
      int w0 = w_cnt;
      int r0 = r_cnt;
      int t0 = tx_log.size();
      bus_gnt = 1'b1;
      send_byte(8'h04);
      send_byte(8'h12);
      send_byte(8'h34);
      wait_idle("write");
      total++; if (w_cnt - w0 !== 1)                  $display("FAIL write w pulses: got %0d required 1", w_cnt - w0); else passed++;
      total++; if (w_addr !== {12'hFFE, 3'h2})       $display("FAIL write addr: got %h required %h", w_addr, {12'hFFE, 3'h2}); else passed++;
      total++; if (w_data !== 16'h1234)              $display("FAIL write data: got %h required 1234", w_data); else passed++;
      total++; if (r_cnt - r0 !== 0)                  $display("FAIL write r pulses: got %0d required 0", r_cnt - r0); else passed++;
      total++; if (tx_log.size() - t0 !== 0)          $display("FAIL write tx bytes: got %0d required 0", tx_log.size() - t0); else passed++;
      bus_gnt = 1'b0;
      tick();
   endtask

   task automatic test_read();
      int w0 = w_cnt;
      int r0 = r_cnt;
      int t0 = tx_log.size();
      rd_val   = 16'hBEEF;
      bus_gnt  = 1'b1;
      tx_ready = 1'b1;
      send_byte(8'h86);
      wait_tx("read", t0 + 2);
      wait_idle("read");
      total++; if (r_cnt - r0 !== 1)              $display("FAIL read r pulses: got %0d required 1", r_cnt - r0); else passed++;
      total++; if (r_addr !== {12'hFFE, 3'h3})   $display("FAIL read addr: got %h required %h", r_addr, {12'hFFE, 3'h3}); else passed++;
      total++; if (w_cnt - w0 !== 0)              $display("FAIL read w pulses: got %0d required 0", w_cnt - w0); else passed++;
      total++; if (tx_log[t0] !== 8'hBE)          $display("FAIL read tx hi: got %h required BE", tx_log[t0]); else passed++;
      total++; if (tx_log[t0+1] !== 8'hEF)        $display("FAIL read tx lo: got %h required EF", tx_log[t0+1]); else passed++;
      total++; if (tx_log.size() - t0 !== 2)      $display("FAIL read tx count: got %0d required 2", tx_log.size() - t0); else passed++;
      bus_gnt  = 1'b0;
      tx_ready = 1'b0;
      tick();
   endtask

   task automatic test_illegal();
      int w0 = w_cnt;
      int r0 = r_cnt;
      int t0 = tx_log.size();
      bus_gnt  = 1'b1;
      tx_ready = 1'b1;
      send_byte(8'h41);
      wait_idle("illegal");
      tick(); tick();
      total++; if (tx_log.size() - t0 !== 1)   $display("FAIL illegal tx count: got %0d required 1", tx_log.size() - t0); else passed++;
      total++; if (tx_log[t0] !== 8'hEE)       $display("FAIL illegal tx byte: got %h required EE", tx_log[t0]); else passed++;
      total++; if (r_cnt - r0 !== 0)           $display("FAIL illegal r pulses: got %0d required 0", r_cnt - r0); else passed++;
      total++; if (w_cnt - w0 !== 0)           $display("FAIL illegal w pulses: got %0d required 0", w_cnt - w0); else passed++;
      total++; if (rx_ready !== 1'b1)          $display("FAIL illegal back to idle rx_ready: got %b required 1", rx_ready); else passed++;
      bus_gnt  = 1'b0;
      tx_ready = 1'b0;
   endtask

   task automatic test_grant_stall();
      int t0 = tx_log.size();
      int bad_req = 0;
      int bad_r = 0;
      int bad_rx = 0;
      rd_val   = 16'hBEEF;
      bus_gnt  = 1'b0;
      tx_ready = 1'b1;
      send_byte(8'h86);
      for (int i = 0; i < 10; i++) begin
         if (bus_req !== 1'b1) bad_req++;
         if (r !== 1'b0) bad_r++;
         if (rx_ready !== 1'b0) bad_rx++;
         tick();
      end
      total++; if (bad_req !== 0) $display("FAIL stall bus_req: %0d cycles low, required 0", bad_req); else passed++;
      total++; if (bad_r !== 0)   $display("FAIL stall r: %0d cycles high, required 0", bad_r); else passed++;
      total++; if (bad_rx !== 0)  $display("FAIL stall rx_ready: %0d cycles high, required 0", bad_rx); else passed++;
      bus_gnt = 1'b1;
      tick();
      bus_gnt = 1'b0;
      total++; if (r !== 1'b1)   $display("FAIL stall r after gnt: got %b required 1", r); else passed++;
      wait_tx("stall", t0 + 2);
      wait_idle("stall");
      total++; if (tx_log[t0] !== 8'hBE)   $display("FAIL stall tx hi: got %h required BE", tx_log[t0]); else passed++;
      total++; if (tx_log[t0+1] !== 8'hEF) $display("FAIL stall tx lo: got %h required EF", tx_log[t0+1]); else passed++;
      tx_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int t0 = tx_log.size();
      int bad = 0;
      bit seen = 0;
      rd_val   = 16'hBEEF;
      bus_gnt  = 1'b1;
      tx_ready = 1'b0;
      send_byte(8'h86);
      for (int i = 0; i < 20; i++) begin
         if (tx_valid) begin
            seen = 1;
            break;
         end
         tick();
      end
      total++; if (!seen) $display("FAIL backpressure tx_valid timeout: got %b required 1", tx_valid); else passed++;
      for (int i = 0; i < 5; i++) begin
         if (tx_valid !== 1'b1 || tx_data !== 8'hBE || rx_ready !== 1'b0) bad++;
         tick();
      end
      total++; if (bad !== 0)     $display("FAIL backpressure hold: %0d unstable cycles, required 0", bad); else passed++;
      total++; if (tx_data !== 8'hBE) $display("FAIL backpressure tx_data: got %h required BE", tx_data); else passed++;
      tx_ready = 1'b1;
      wait_tx("backpressure", t0 + 2);
      wait_idle("backpressure");
      total++; if (tx_log[t0] !== 8'hBE)   $display("FAIL backpressure tx hi: got %h required BE", tx_log[t0]); else passed++;
      total++; if (tx_log[t0+1] !== 8'hEF) $display("FAIL backpressure tx lo: got %h required EF", tx_log[t0+1]); else passed++;
      bus_gnt  = 1'b0;
      tx_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int w0 = w_cnt;
      bus_gnt = 1'b1;
      send_byte(8'h04);
      send_byte(8'h12);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if (busy !== 1'b0)     $display("FAIL midreset busy: got %b required 0", busy); else passed++;
      total++; if (rx_ready !== 1'b1) $display("FAIL midreset rx_ready: got %b required 1", rx_ready); else passed++;
      tick(); tick(); tick();
      total++; if (w_cnt - w0 !== 0)  $display("FAIL midreset w pulses: got %0d required 0", w_cnt - w0); else passed++;
      send_byte(8'h04);
      send_byte(8'hAB);
      send_byte(8'hCD);
      wait_idle("midreset");
      total++; if (w_cnt - w0 !== 1)          $display("FAIL midreset rewrite pulses: got %0d required 1", w_cnt - w0); else passed++;
      total++; if (w_data !== 16'hABCD)       $display("FAIL midreset rewrite data: got %h required ABCD", w_data); else passed++;
      total++; if (w_addr !== {12'hFFE, 3'h2}) $display("FAIL midreset rewrite addr: got %h required %h", w_addr, {12'hFFE, 3'h2}); else passed++;
      bus_gnt = 1'b0;
   endtask

   task automatic test_back_to_back();
      int w0 = w_cnt;
      bus_gnt = 1'b1;
      send_byte(8'h0A);
      send_byte(8'h55);
      send_byte(8'h66);
      send_byte(8'h0E);
      send_byte(8'h9A);
      send_byte(8'hBC);
      wait_idle("back_to_back");
      total++; if (w_cnt - w0 !== 2)           $display("FAIL b2b w pulses: got %0d required 2", w_cnt - w0); else passed++;
      total++; if (w_addr !== {12'hFFE, 3'h7}) $display("FAIL b2b addr: got %h required %h", w_addr, {12'hFFE, 3'h7}); else passed++;
      total++; if (w_data !== 16'h9ABC)        $display("FAIL b2b data: got %h required 9ABC", w_data); else passed++;
      total++; if (both_cnt !== 0)             $display("FAIL r_w_exclusive: got %0d overlaps required 0", both_cnt); else passed++;
      bus_gnt = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_illegal();
      test_grant_stall();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
